// File: rtl/stark_branch_issuer_if.sv
// Dispatch/wakeup/station-side signal bundle for stark_branch_issuer.
// Latency: n/a (wires only).
// Backpressure: enq_ok_o tells dispatch whether the queue can take another op.
//
// Parameters: DEPTH (queue entries, sizes count_o), NDX_W (ROB index width).
// master: dispatch/rename + station side (drives enq/wake/flush/idle).
// slave : the issuer (drives enq_ok_o, issue, rndx, rndxv, count_o, ovf_o).
interface stark_branch_issuer_if #(
    parameter int DEPTH = 4,
    parameter int NDX_W = 6
);
    logic                     enq_v;
    logic [NDX_W-1:0]         enq_ndx;
    logic                     enq_rdy;
    logic                     wake_v;
    logic [NDX_W-1:0]         wake_ndx;
    logic                     flush_i;
    logic                     bs_idle_i;
    logic                     enq_ok_o;
    logic                     issue;
    logic [NDX_W-1:0]         rndx;
    logic                     rndxv;
    logic [$clog2(DEPTH):0]   count_o;
    logic                     ovf_o;

    modport master (
        output enq_v, enq_ndx, enq_rdy, wake_v, wake_ndx, flush_i, bs_idle_i,
        input  enq_ok_o, issue, rndx, rndxv, count_o, ovf_o
    );

    modport slave (
        input  enq_v, enq_ndx, enq_rdy, wake_v, wake_ndx, flush_i, bs_idle_i,
        output enq_ok_o, issue, rndx, rndxv, count_o, ovf_o
    );
endinterface

// File: rtl/stark_branch_issuer.sv
// In-order branch issue queue feeding the Stark branch reservation station.
// Latency: ready enqueue into an empty queue issues one edge later (same edge with bypass).
// Backpressure: enq_ok_o low when full; refused enqueues set sticky ovf_o. Issue paced by bs_idle_i + holdoff.
//
// Ports: clk, rst (async active-low), bus (stark_branch_issuer_if.slave).
// Optional feature: STARK_BRISSUE_BYPASS_EN -- a ready enqueue into an empty,
// idle queue issues directly without occupying an entry.
module stark_branch_issuer #(
    parameter int DEPTH   = 4,
    parameter int HOLDOFF = 1,
    parameter int NDX_W   = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    stark_branch_issuer_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int HW = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);

    typedef logic [NDX_W-1:0] rob_ndx_t;

    logic     ent_vld [DEPTH];
    logic     ent_rdy [DEPTH];
    rob_ndx_t ent_ndx [DEPTH];

    logic [PW-1:0] head_q;
    logic [PW-1:0] tail_q;
    logic [CW-1:0] count_q;
    logic [HW-1:0] hold_q;
    logic          ovf_q;
    logic          issue_q;
    rob_ndx_t      rndx_q;

    logic     full;
    logic     hold_zero;
    logic     eligible;
    logic     bypass;
    logic     do_enq;
    logic     do_iss;
    rob_ndx_t iss_ndx;

    assign full      = (count_q == CW'(DEPTH));
    assign hold_zero = (hold_q == '0);

    // Eligibility uses the registered ready bit: a wakeup lands at one edge
    // and the issue is registered at the following edge.
    assign eligible = ent_vld[head_q] && ent_rdy[head_q] && bus.bs_idle_i
                   && hold_zero && !bus.flush_i;

`ifdef STARK_BRISSUE_BYPASS_EN
    assign bypass = bus.enq_v && bus.enq_rdy && (count_q == '0) && bus.bs_idle_i
                 && hold_zero && !bus.flush_i;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed op never occupies an entry.
    assign do_enq  = bus.enq_v && !full && !bus.flush_i && !bypass;
    assign do_iss  = eligible || bypass;
    assign iss_ndx = bypass ? bus.enq_ndx : ent_ndx[head_q];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_vld[i] <= 1'b0;
                ent_rdy[i] <= 1'b0;
                ent_ndx[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            hold_q  <= '0;
            ovf_q   <= 1'b0;
            issue_q <= 1'b0;
            rndx_q  <= '0;
        end else begin
            // Overflow records the attempt, independent of flush.
            if (bus.enq_v && full) begin
                ovf_q <= 1'b1;
            end

            if (bus.flush_i) begin
                for (int i = 0; i < DEPTH; i++) begin
                    ent_vld[i] <= 1'b0;
                end
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
                hold_q  <= '0;
                issue_q <= 1'b0;
            end else begin
                issue_q <= do_iss;
                if (do_iss) begin
                    rndx_q <= iss_ndx;
                    hold_q <= HW'(HOLDOFF);
                end else if (!hold_zero) begin
                    hold_q <= hold_q - 1'b1;
                end

                if (bus.wake_v) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        if (ent_vld[i] && ent_ndx[i] == bus.wake_ndx) begin
                            ent_rdy[i] <= 1'b1;
                        end
                    end
                end

                // Tail slot is never the issuing head here: enqueue needs
                // not-full, issue needs non-empty, so they differ.
                if (do_enq) begin
                    ent_vld[tail_q] <= 1'b1;
                    ent_rdy[tail_q] <= bus.enq_rdy
                                    || (bus.wake_v && bus.wake_ndx == bus.enq_ndx);
                    ent_ndx[tail_q] <= bus.enq_ndx;
                    tail_q          <= tail_q + 1'b1;
                end

                if (eligible) begin
                    ent_vld[head_q] <= 1'b0;
                    head_q          <= head_q + 1'b1;
                end

                case ({do_enq, eligible})
                    2'b10:   count_q <= count_q + 1'b1;
                    2'b01:   count_q <= count_q - 1'b1;
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    assign bus.enq_ok_o = !full;
    assign bus.issue    = issue_q;
    assign bus.rndxv    = issue_q;
    assign bus.rndx     = rndx_q;
    assign bus.count_o  = count_q;
    assign bus.ovf_o    = ovf_q;
endmodule

// File: tb/tb_stark_branch_issuer.sv
module tb_stark_branch_issuer;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    stark_branch_issuer_if #(.DEPTH(4), .NDX_W(6)) bus ();

    stark_branch_issuer #(.DEPTH(4), .HOLDOFF(1), .NDX_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic enq(input logic [5:0] n, input logic r);
        bus.enq_v   = 1'b1;
        bus.enq_ndx = n;
        bus.enq_rdy = r;
        step();
        bus.enq_v   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   waited;
        logic [5:0] exp_ndx;
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        bus.enq_v = 1'b0; bus.enq_ndx = '0; bus.enq_rdy = 1'b0;
        bus.wake_v = 1'b0; bus.wake_ndx = '0;
        bus.flush_i = 1'b0; bus.bs_idle_i = 1'b0;

        // Reset values
        step(); step();
        chk("rst_issue", bus.issue, 0);
        chk("rst_rndxv", bus.rndxv, 0);
        chk("rst_rndx", bus.rndx, 0);
        chk("rst_count", bus.count_o, 0);
        chk("rst_enq_ok", bus.enq_ok_o, 1);
        chk("rst_ovf", bus.ovf_o, 0);
        rst = 1'b1;
        step();

        // Ready op into empty queue, station idle
        bus.bs_idle_i = 1'b1;
        enq(6'd5, 1'b1);
`ifdef STARK_BRISSUE_BYPASS_EN
        chk("t1_issue_e0", bus.issue, 1);
        chk("t1_rndx_e0", bus.rndx, 5);
        chk("t1_count_e0", bus.count_o, 0);
        step();
        chk("t1_issue_drop", bus.issue, 0);
`else
        chk("t1_issue_e0", bus.issue, 0);
        chk("t1_count_e0", bus.count_o, 1);
        step();
        chk("t1_issue_e1", bus.issue, 1);
        chk("t1_rndxv_e1", bus.rndxv, 1);
        chk("t1_rndx_e1", bus.rndx, 5);
        chk("t1_count_e1", bus.count_o, 0);
        step();
        chk("t1_issue_drop", bus.issue, 0);
        chk("t1_rndx_hold", bus.rndx, 5);
`endif
        step();

        // Not-ready head blocks a younger ready entry
        enq(6'd3, 1'b0);
        enq(6'd4, 1'b1);
        chk("t2_count", bus.count_o, 2);
        step(); step();
        chk("t2_blocked", bus.issue, 0);
        chk("t2_count_hold", bus.count_o, 2);
        bus.wake_v = 1'b1; bus.wake_ndx = 6'd3;
        step();
        bus.wake_v = 1'b0;
        chk("t2_wake_e0", bus.issue, 0);
        step();
        chk("t2_issue3", bus.issue, 1);
        chk("t2_rndx3", bus.rndx, 3);
        chk("t2_count1", bus.count_o, 1);
        step();
        chk("t2_holdoff", bus.issue, 0);
        step();
        chk("t2_issue4", bus.issue, 1);
        chk("t2_rndx4", bus.rndx, 4);
        chk("t2_count0", bus.count_o, 0);
        step();

        // Fill, overflow, ordered drain, wrapped refill
        bus.bs_idle_i = 1'b0;
        for (int i = 0; i < 4; i++) enq(6'(10 + i), 1'b1);
        chk("t3_full_count", bus.count_o, 4);
        chk("t3_full_ok", bus.enq_ok_o, 0);
        chk("t3_no_ovf_yet", bus.ovf_o, 0);
        enq(6'd14, 1'b1);
        chk("t3_ovf", bus.ovf_o, 1);
        chk("t3_ovf_count", bus.count_o, 4);
        chk("t3_ovf_ok", bus.enq_ok_o, 0);
        for (int pass = 0; pass < 2; pass++) begin
            bus.bs_idle_i = 1'b1;
            for (int k = 0; k < 4; k++) begin
                step();
                exp_ndx = 6'((pass == 0 ? 10 : 20) + k);
                chk("t3_drain_issue", bus.issue, 1);
                chk("t3_drain_rndx", bus.rndx, exp_ndx);
                chk("t3_drain_count", bus.count_o, 32'(3 - k));
                step();
                chk("t3_drain_gap", bus.issue, 0);
            end
            if (pass == 0) begin
                bus.bs_idle_i = 1'b0;
                for (int i = 0; i < 4; i++) enq(6'(20 + i), 1'b1);
                chk("t3_refill_count", bus.count_o, 4);
            end
        end

        // Flush beats eligible head and same-cycle enqueue
        bus.bs_idle_i = 1'b0;
        for (int i = 0; i < 3; i++) enq(6'(30 + i), 1'b1);
        bus.bs_idle_i = 1'b1;
        bus.flush_i   = 1'b1;
        enq(6'd33, 1'b1);
        bus.flush_i   = 1'b0;
        chk("t4_issue", bus.issue, 0);
        chk("t4_count", bus.count_o, 0);
        chk("t4_enq_ok", bus.enq_ok_o, 1);
        chk("t4_ovf_kept", bus.ovf_o, 1);
        step();
        chk("t4_issue_after", bus.issue, 0);
        chk("t4_count_after", bus.count_o, 0);

        // Wakeup matching the index being enqueued
        bus.wake_v = 1'b1; bus.wake_ndx = 6'd40;
        enq(6'd40, 1'b0);
        bus.wake_v = 1'b0;
        chk("t5_e0", bus.issue, 0);
        step();
        chk("t5_issue", bus.issue, 1);
        chk("t5_rndx", bus.rndx, 40);
        step();

        // Async reset while issue is high
        enq(6'd9, 1'b1);
        waited = 0;
        while (bus.issue !== 1'b1 && waited < 3) begin
            step();
            waited++;
        end
        chk("t6_issue_seen", bus.issue, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_issue", bus.issue, 0);
        chk("t6_rndxv", bus.rndxv, 0);
        chk("t6_rndx", bus.rndx, 0);
        chk("t6_count", bus.count_o, 0);
        chk("t6_enq_ok", bus.enq_ok_o, 1);
        chk("t6_ovf", bus.ovf_o, 0);
        step();
        rst = 1'b1;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
